// File: rtl/branch_pkg.sv
// branch_pkg: shared types and constants for the branch resolve sequencer
package branch_pkg;
   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } br_funct3_e;
   typedef enum logic [1:0] {IDLE, EVAL, FLUSH} brc_state_e;
   localparam logic [1:0] BHT_RESET = 2'b01;
   function automatic logic f3_legal(input logic [2:0] f);
      return f[2:1] != 2'b01;
   endfunction
endpackage

// File: rtl/bht_bimodal.sv
// bht_bimodal: array of 2-bit saturating counters, async read, sync update
module bht_bimodal import branch_pkg::*; #(
   parameter int ENTRIES = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
   output logic                       rd_taken_o,
   input  logic                       upd_en_i,
   input  logic [$clog2(ENTRIES)-1:0] upd_idx_i,
   input  logic                       upd_taken_i
);
   logic [1:0] ctr_q [ENTRIES];
   logic [1:0] cur;
   assign cur = ctr_q[upd_idx_i];
   assign rd_taken_o = ctr_q[rd_idx_i][1];
   // saturating counter update; reads see the pre-update value
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_RESET;
      end else if (upd_en_i) begin
         ctr_q[upd_idx_i] <= upd_taken_i ? ((cur == 2'b11) ? cur : cur + 2'b01)
                                         : ((cur == 2'b00) ? cur : cur - 2'b01);
      end
   end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequences one branch through compare, resolves, redirects and flushes
module branch_resolve_ctrl import branch_pkg::*; #(
   parameter int XLEN         = 32,
   parameter int BHT_ENTRIES  = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid_i,
   output logic            br_ready_o,
   input  logic [2:0]      br_funct3_i,
   input  logic [XLEN-1:0] br_pc_i,
   input  logic [XLEN-1:0] br_imm_i,
   input  logic [XLEN-1:0] br_op_a_i,
   input  logic [XLEN-1:0] br_op_b_i,
   input  logic            br_pred_taken_i,
   output logic [2:0]      cmp_ctrl_o,
   output logic [XLEN-1:0] cmp_src_a_o,
   output logic [XLEN-1:0] cmp_src_b_o,
   input  logic            cmp_out_i,
   input  logic [XLEN-1:0] if_pc_i,
   output logic            if_pred_taken_o,
   output logic            resolve_valid_o,
   output logic            resolve_taken_o,
   output logic            br_illegal_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            flush_o,
   output logic [15:0]     mispredict_cnt_o
);
   localparam int IW = $clog2(BHT_ENTRIES);
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   brc_state_e      state_q;
   logic [XLEN-1:0] pc_q, imm_q, op_a_q, op_b_q, redirect_pc_q;
   logic [2:0]      cmp_ctrl_q;
   logic            pred_q, resolve_valid_q, resolve_taken_q, br_illegal_q;
   logic            redirect_valid_q, flush_q;
   logic [FW-1:0]   fl_cnt_q;
   logic [15:0]     cnt_q;
   logic            mispredict;
   logic [XLEN-1:0] target;
   assign mispredict = cmp_out_i != pred_q;
   assign target = cmp_out_i ? pc_q + imm_q : pc_q + XLEN'(4);
   assign br_ready_o = state_q == IDLE;
   assign cmp_ctrl_o = cmp_ctrl_q;
   assign cmp_src_a_o = op_a_q;
   assign cmp_src_b_o = op_b_q;
   assign resolve_valid_o = resolve_valid_q;
   assign resolve_taken_o = resolve_taken_q;
   assign br_illegal_o = br_illegal_q;
   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o = redirect_pc_q;
   assign flush_o = flush_q;
   assign mispredict_cnt_o = cnt_q;
   // accept -> evaluate -> optionally hold flush, all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         pc_q             <= '0;
         imm_q            <= '0;
         op_a_q           <= '0;
         op_b_q           <= '0;
         pred_q           <= 1'b0;
         cmp_ctrl_q       <= '0;
         resolve_valid_q  <= 1'b0;
         resolve_taken_q  <= 1'b0;
         br_illegal_q     <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
         fl_cnt_q         <= '0;
         cnt_q            <= '0;
      end else begin
         resolve_valid_q  <= 1'b0;
         br_illegal_q     <= 1'b0;
         redirect_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (br_valid_i) begin
               pc_q   <= br_pc_i;
               imm_q  <= br_imm_i;
               op_a_q <= br_op_a_i;
               op_b_q <= br_op_b_i;
               pred_q <= br_pred_taken_i;
               if (f3_legal(br_funct3_i)) begin
                  cmp_ctrl_q <= br_funct3_i;
                  state_q    <= EVAL;
               end else begin
                  br_illegal_q <= 1'b1;
               end
            end
            EVAL: begin
               cmp_ctrl_q      <= '0;
               resolve_valid_q <= 1'b1;
               resolve_taken_q <= cmp_out_i;
               if (mispredict) begin
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= target;
                  flush_q          <= 1'b1;
                  cnt_q            <= cnt_q + 16'd1;
                  fl_cnt_q         <= FW'(FLUSH_CYCLES - 1);
                  state_q          <= FLUSH;
               end else begin
                  state_q <= IDLE;
               end
            end
            FLUSH: if (fl_cnt_q == '0) begin
               flush_q <= 1'b0;
               state_q <= IDLE;
            end else begin
               fl_cnt_q <= fl_cnt_q - 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   bht_bimodal #(.ENTRIES(BHT_ENTRIES)) u_bht (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (if_pc_i[IW+1:2]),
      .rd_taken_o  (if_pred_taken_o),
      .upd_en_i    (state_q == EVAL),
      .upd_idx_i   (pc_q[IW+1:2]),
      .upd_taken_i (cmp_out_i)
   );
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and random branches against a behavioural model
module tb_branch_resolve_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        br_valid, br_ready, br_pred_taken, cmp_out, if_pred_taken;
   logic [2:0]  br_funct3, cmp_ctrl;
   logic [31:0] br_pc, br_imm, br_op_a, br_op_b, cmp_src_a, cmp_src_b, if_pc, redirect_pc;
   logic        resolve_valid, resolve_taken, br_illegal, redirect_valid, flush;
   logic [15:0] mispredict_cnt;
   int          n_tests = 0;
   int          n_fail = 0;
   int          bht [16];
   int          m_cnt;

   branch_resolve_ctrl dut (
      .clk(clk), .rst(rst),
      .br_valid_i(br_valid), .br_ready_o(br_ready), .br_funct3_i(br_funct3),
      .br_pc_i(br_pc), .br_imm_i(br_imm), .br_op_a_i(br_op_a), .br_op_b_i(br_op_b),
      .br_pred_taken_i(br_pred_taken), .cmp_ctrl_o(cmp_ctrl),
      .cmp_src_a_o(cmp_src_a), .cmp_src_b_o(cmp_src_b), .cmp_out_i(cmp_out),
      .if_pc_i(if_pc), .if_pred_taken_o(if_pred_taken),
      .resolve_valid_o(resolve_valid), .resolve_taken_o(resolve_taken),
      .br_illegal_o(br_illegal), .redirect_valid_o(redirect_valid),
      .redirect_pc_o(redirect_pc), .flush_o(flush), .mispredict_cnt_o(mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         default: return a >= b;
      endcase
   endfunction

   function automatic logic ref_pred(input logic [31:0] pc);
      return bht[pc[5:2]] >= 2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) bht[i] = 1;
      m_cnt = 0;
   endtask

   task automatic run_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] a, input logic [31:0] b, input logic pred,
                             input bit hold = 0);
      logic tk, mis;
      logic [31:0] tgt;
      br_valid = 1'b1; br_funct3 = f3; br_pc = pc; br_imm = imm;
      br_op_a = a; br_op_b = b; br_pred_taken = pred; if_pc = pc;
      chk("ready_before", {31'b0, br_ready}, 32'd1);
      @(posedge clk); #1;
      br_valid = 1'b0;
      if (f3 == 3'b010 || f3 == 3'b011) begin
         chk("illegal_pulse", {31'b0, br_illegal}, 32'd1);
         chk("illegal_no_resolve", {31'b0, resolve_valid}, 32'd0);
         chk("illegal_ready", {31'b0, br_ready}, 32'd1);
         chk("illegal_bht", {31'b0, if_pred_taken}, {31'b0, ref_pred(pc)});
         return;
      end
      tk = ref_taken(f3, a, b);
      mis = tk != pred;
      tgt = tk ? pc + imm : pc + 32'd4;
      chk("eval_ctrl", {29'b0, cmp_ctrl}, {29'b0, f3});
      chk("eval_src_a", cmp_src_a, a);
      chk("eval_src_b", cmp_src_b, b);
      chk("eval_ready", {31'b0, br_ready}, 32'd0);
      chk("eval_bht_old", {31'b0, if_pred_taken}, {31'b0, ref_pred(pc)});
      cmp_out = tk;
      @(posedge clk); #1;
      cmp_out = 1'b0;
      bht[pc[5:2]] = tk ? ((bht[pc[5:2]] == 3) ? 3 : bht[pc[5:2]] + 1)
                        : ((bht[pc[5:2]] == 0) ? 0 : bht[pc[5:2]] - 1);
      if (mis) m_cnt = (m_cnt + 1) % 65536;
      chk("res_valid", {31'b0, resolve_valid}, 32'd1);
      chk("res_taken", {31'b0, resolve_taken}, {31'b0, tk});
      chk("redir_valid", {31'b0, redirect_valid}, {31'b0, mis});
      chk("flush_first", {31'b0, flush}, {31'b0, mis});
      chk("mis_cnt", {16'b0, mispredict_cnt}, m_cnt);
      chk("ready_t2", {31'b0, br_ready}, {31'b0, !mis});
      chk("bht_new", {31'b0, if_pred_taken}, {31'b0, ref_pred(pc)});
      if (mis) begin
         chk("redir_pc", redirect_pc, tgt);
         if (hold) br_valid = 1'b1;
         @(posedge clk); #1;
         chk("flush_second", {31'b0, flush}, 32'd1);
         chk("redir_once", {31'b0, redirect_valid}, 32'd0);
         chk("flush_ready", {31'b0, br_ready}, 32'd0);
         chk("flush_no_accept", {29'b0, cmp_ctrl}, 32'd0);
         @(posedge clk); #1;
         chk("flush_end", {31'b0, flush}, 32'd0);
         chk("ready_after", {31'b0, br_ready}, 32'd1);
         chk("no_accept_flush", {29'b0, cmp_ctrl}, 32'd0);
      end
   endtask

   initial begin
      logic [2:0] f3s [8];
      f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
      rst = 1'b1; br_valid = 1'b0; br_funct3 = '0; br_pc = '0; br_imm = '0;
      br_op_a = '0; br_op_b = '0; br_pred_taken = 1'b0; cmp_out = 1'b0; if_pc = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", {31'b0, br_ready}, 32'd1);
      chk("rst_pred0", {31'b0, if_pred_taken}, 32'd0);
      if_pc = 32'h3C; #1;
      chk("rst_pred3c", {31'b0, if_pred_taken}, 32'd0);
      chk("rst_cnt", {16'b0, mispredict_cnt}, 32'd0);
      chk("rst_flush", {31'b0, flush}, 32'd0);
      chk("rst_ctrl", {29'b0, cmp_ctrl}, 32'd0);
      chk("rst_redir_pc", redirect_pc, 32'd0);
      run_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
      if_pc = 32'h100; #1;
      chk("bht0_msb", {31'b0, if_pred_taken}, 32'd1);
      run_branch(3'b110, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_branch(3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0);
      for (int i = 0; i < 3; i++) run_branch(3'b001, 32'h40, 32'h8, 32'd1, 32'd2, 1'b1);
      run_branch(3'b010, 32'h80, 32'h8, 32'd1, 32'd1, 1'b0);
      run_branch(3'b101, 32'h300, 32'h40, 32'd7, 32'd3, 1'b0, 1);
      run_branch(3'b101, 32'h300, 32'h40, 32'd7, 32'd3, 1'b1);
      br_valid = 1'b1; br_funct3 = 3'b000; br_pc = 32'h40; br_imm = 32'h4;
      br_op_a = 32'd9; br_op_b = 32'd9; br_pred_taken = 1'b0; if_pc = 32'h40;
      @(posedge clk); #1;
      br_valid = 1'b0; cmp_out = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; cmp_out = 1'b0;
      model_reset();
      chk("abort_ready", {31'b0, br_ready}, 32'd1);
      chk("abort_resolve", {31'b0, resolve_valid}, 32'd0);
      chk("abort_redir", {31'b0, redirect_valid}, 32'd0);
      chk("abort_flush", {31'b0, flush}, 32'd0);
      chk("abort_cnt", {16'b0, mispredict_cnt}, 32'd0);
      chk("abort_bht", {31'b0, if_pred_taken}, 32'd0);
      @(posedge clk); #1;
      chk("abort_no_late", {31'b0, resolve_valid | redirect_valid}, 32'd0);
      run_branch(3'b000, 32'hFFFF_FFFC, 32'd8, 32'd1, 32'd1, 1'b0);
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         run_branch(f3s[$urandom_range(0, 7)], $urandom, $urandom, a, b, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
